cv32e40p_multi_sleep_unit: RTL and testbench

CV32E40P_MULTI_SLEEP_UNIT -- requirements
Module: cv32e40p_multi_sleep_unit

---
 rtl/cv32e40p_multi_sleep_unit.sv | 160 ++++++++++++++++
 tb/tb_cv32e40p_multi_sleep_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_multi_sleep_unit.sv
// Per-domain sleep controller: one OFF/RUN/IDLE/SLEEP/WAKE machine plus a latch-based clock gate for each domain.
// Optional sleep-cycle statistics counter is built only when CV32E40P_SLEEP_STATS_EN is defined.

module cv32e40p_sleep_clock_gate (
  input  logic clk_i,
  input  logic en_i,
  input  logic scan_cg_en_i,
  output logic clk_o
);

  logic en_latch;

  // Enable is captured only while the clock is low, so the AND below cannot glitch.
  always_latch begin
    if (!clk_i) en_latch <= en_i | scan_cg_en_i;
  end

  assign clk_o = clk_i & en_latch;

endmodule

module cv32e40p_multi_sleep_unit #(
  parameter int unsigned NUM_DOMAINS = 4,
  parameter int unsigned IDLE_CNT_W  = 4,
  parameter int unsigned WAKE_DLY    = 2
) (
  input  logic                   clk_ungated_i,
  input  logic                   rst_n,
  input  logic                   scan_cg_en_i,
  input  logic                   clk_en_ext_i,
  input  logic                   fetch_enable_i,
  output logic                   fetch_enable_o,
  input  logic [NUM_DOMAINS-1:0] dom_busy_i,
  input  logic [NUM_DOMAINS-1:0] dom_wake_i,
  input  logic [IDLE_CNT_W-1:0]  idle_thresh_i,
  output logic [NUM_DOMAINS-1:0] clk_gated_o,
  output logic [NUM_DOMAINS-1:0] dom_sleep_o,
  output logic                   core_sleep_o,
  output logic [15:0]            sleep_cnt_o
);

  typedef enum logic [2:0] {
    S_OFF,
    S_RUN,
    S_IDLE,
    S_SLEEP,
    S_WAKE
  } dom_state_e;

  localparam logic [2:0] WAKE_CNT_INIT = 3'(WAKE_DLY);

  logic fetch_enable_q, fetch_enable_d;
  logic [NUM_DOMAINS-1:0] dom_en;

  assign fetch_enable_d = fetch_enable_q | fetch_enable_i;

  always_ff @(posedge clk_ungated_i or negedge rst_n) begin
    if (!rst_n) fetch_enable_q <= 1'b0;
    else        fetch_enable_q <= fetch_enable_d;
  end

  assign fetch_enable_o = fetch_enable_q;

  for (genvar i = 0; i < NUM_DOMAINS; i++) begin : g_dom
    dom_state_e            state_q, state_d;
    logic [IDLE_CNT_W-1:0] idle_cnt_q, idle_cnt_d;
    logic [2:0]            wake_cnt_q, wake_cnt_d;
    logic                  act;

    // Busy and wake together are a single wake event.
    assign act = dom_busy_i[i] | dom_wake_i[i];

    always_comb begin
      state_d    = state_q;
      idle_cnt_d = idle_cnt_q;
      wake_cnt_d = wake_cnt_q;
      case (state_q)
        S_OFF: begin
          if (fetch_enable_q) state_d = S_RUN;
        end
        S_RUN: begin
          if (!dom_busy_i[i]) begin
            if (idle_thresh_i == '0) begin
              state_d = S_SLEEP;
            end else begin
              state_d    = S_IDLE;
              idle_cnt_d = idle_thresh_i;
            end
          end
        end
        S_IDLE: begin
          if (act)                                 state_d = S_RUN;
          else if (idle_cnt_q == IDLE_CNT_W'(1))   state_d = S_SLEEP;
          else                                     idle_cnt_d = idle_cnt_q - 1'b1;
        end
        S_SLEEP: begin
          if (act) begin
            if (WAKE_DLY == 0) begin
              state_d = S_RUN;
            end else begin
              state_d    = S_WAKE;
              wake_cnt_d = WAKE_CNT_INIT;
            end
          end
        end
        S_WAKE: begin
          if (wake_cnt_q == 3'd1) state_d = S_RUN;
          else                    wake_cnt_d = wake_cnt_q - 3'd1;
        end
        default: state_d = S_OFF;
      endcase
    end

    always_ff @(posedge clk_ungated_i or negedge rst_n) begin
      if (!rst_n) begin
        state_q    <= S_OFF;
        idle_cnt_q <= '0;
        wake_cnt_q <= '0;
      end else begin
        state_q    <= state_d;
        idle_cnt_q <= idle_cnt_d;
        wake_cnt_q <= wake_cnt_d;
      end
    end

    // The raw wake input re-opens the gate in the very cycle it arrives.
    assign dom_en[i] = fetch_enable_q & clk_en_ext_i &
                       (((state_q != S_OFF) && (state_q != S_SLEEP)) | dom_wake_i[i]);

    assign dom_sleep_o[i] = (state_q == S_SLEEP);

    cv32e40p_sleep_clock_gate u_cg (
      .clk_i        (clk_ungated_i),
      .en_i         (dom_en[i]),
      .scan_cg_en_i (scan_cg_en_i),
      .clk_o        (clk_gated_o[i])
    );
  end

  assign core_sleep_o = fetch_enable_q & (&dom_sleep_o);

`ifdef CV32E40P_SLEEP_STATS_EN
  logic [15:0] sleep_cnt_q, sleep_cnt_d;

  always_comb begin
    sleep_cnt_d = sleep_cnt_q;
    if (core_sleep_o && (sleep_cnt_q != 16'hFFFF)) sleep_cnt_d = sleep_cnt_q + 16'd1;
  end

  always_ff @(posedge clk_ungated_i or negedge rst_n) begin
    if (!rst_n) sleep_cnt_q <= '0;
    else        sleep_cnt_q <= sleep_cnt_d;
  end

  assign sleep_cnt_o = sleep_cnt_q;
`else
  assign sleep_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cv32e40p_multi_sleep_unit.sv
// Directed bench for cv32e40p_multi_sleep_unit (NUM_DOMAINS=4, IDLE_CNT_W=4, WAKE_DLY=2).
// Gated clocks are sampled 1 time unit after each rising edge, so they show the enable of the cycle just ended.

module tb_cv32e40p_multi_sleep_unit;

  logic        clk_ungated_i = 1'b0;
  logic        rst_n;
  logic        scan_cg_en_i;
  logic        clk_en_ext_i;
  logic        fetch_enable_i;
  logic        fetch_enable_o;
  logic [3:0]  dom_busy_i;
  logic [3:0]  dom_wake_i;
  logic [3:0]  idle_thresh_i;
  logic [3:0]  clk_gated_o;
  logic [3:0]  dom_sleep_o;
  logic        core_sleep_o;
  logic [15:0] sleep_cnt_o;

  int errors = 0;
  int checks = 0;

  always #5 clk_ungated_i = ~clk_ungated_i;

  cv32e40p_multi_sleep_unit #(
    .NUM_DOMAINS (4),
    .IDLE_CNT_W  (4),
    .WAKE_DLY    (2)
  ) dut (
    .clk_ungated_i  (clk_ungated_i),
    .rst_n          (rst_n),
    .scan_cg_en_i   (scan_cg_en_i),
    .clk_en_ext_i   (clk_en_ext_i),
    .fetch_enable_i (fetch_enable_i),
    .fetch_enable_o (fetch_enable_o),
    .dom_busy_i     (dom_busy_i),
    .dom_wake_i     (dom_wake_i),
    .idle_thresh_i  (idle_thresh_i),
    .clk_gated_o    (clk_gated_o),
    .dom_sleep_o    (dom_sleep_o),
    .core_sleep_o   (core_sleep_o),
    .sleep_cnt_o    (sleep_cnt_o)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_ungated_i);
    #1;
  endtask

`ifdef CV32E40P_SLEEP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  initial begin
    rst_n = 1'b0; scan_cg_en_i = 1'b0; clk_en_ext_i = 1'b1; fetch_enable_i = 1'b0;
    dom_busy_i = 4'hF; dom_wake_i = 4'h0; idle_thresh_i = 4'd3;

    // reset behaviour
    tick(); tick(); tick();
    chk("rst_clk",   16'(clk_gated_o), 16'h0);
    chk("rst_sleep", 16'(dom_sleep_o), 16'h0);
    chk("rst_core",  16'(core_sleep_o), 16'h0);
    chk("rst_fe",    16'(fetch_enable_o), 16'h0);
    chk("rst_cnt",   sleep_cnt_o, 16'h0);
    scan_cg_en_i = 1'b1;
    tick();
    chk("rst_scan_clk", 16'(clk_gated_o), 16'hF);
    scan_cg_en_i = 1'b0;
    tick();
    chk("rst_noscan_clk", 16'(clk_gated_o), 16'h0);

    // bring-up: fetch enable pulse
    rst_n = 1'b1;
    tick(); tick(); tick(); tick();
    chk("off_clk", 16'(clk_gated_o), 16'h0);
    chk("off_fe",  16'(fetch_enable_o), 16'h0);
    fetch_enable_i = 1'b1;                                   // cycle 5
    tick();                                                  // cycle 6
    fetch_enable_i = 1'b0;
    chk("fe_set",  16'(fetch_enable_o), 16'h1);
    chk("c6_clk",  16'(clk_gated_o), 16'h0);
    tick();                                                  // cycle 7: RUN
    chk("c7_clk",  16'(clk_gated_o), 16'h0);
    chk("c7_core", 16'(core_sleep_o), 16'h0);
    tick();                                                  // cycle 8
    chk("run_clk", 16'(clk_gated_o), 16'hF);
    chk("fe_sticky", 16'(fetch_enable_o), 16'h1);

    // domain 0 idles 3 cycles; threshold change mid-count must not matter
    dom_busy_i = 4'hE;
    tick();                                                  // IDLE 3
    idle_thresh_i = 4'd1;
    chk("idle3_sleep", 16'(dom_sleep_o), 16'h0);
    tick();                                                  // IDLE 2
    chk("idle2_clk", 16'(clk_gated_o), 16'hF);
    tick();                                                  // IDLE 1
    chk("idle1_sleep", 16'(dom_sleep_o), 16'h0);
    tick();                                                  // SLEEP
    chk("d0_sleep",  16'(dom_sleep_o), 16'h1);
    chk("d0_core",   16'(core_sleep_o), 16'h0);
    chk("d0_clk_last", 16'(clk_gated_o), 16'hF);
    tick();
    chk("d0_clk_off", 16'(clk_gated_o), 16'hE);

    // domain 1 idles one cycle then becomes busy again
    idle_thresh_i = 4'd3;
    dom_busy_i = 4'hC;
    tick();                                                  // d1 IDLE
    dom_busy_i = 4'hE;
    tick();                                                  // d1 RUN
    chk("d1_idle_clk", 16'(clk_gated_o), 16'hE);
    tick();
    chk("d1_ret_clk",   16'(clk_gated_o), 16'hE);
    chk("d1_ret_sleep", 16'(dom_sleep_o), 16'h1);

    // zero threshold: all domains sleep the next cycle
    idle_thresh_i = 4'd0;
    dom_busy_i = 4'h0;
    tick();                                                  // all SLEEP
    chk("all_sleep", 16'(dom_sleep_o), 16'hF);
    chk("all_core",  16'(core_sleep_o), 16'h1);
    chk("all_clk_last", 16'(clk_gated_o), 16'hE);
    tick();
    chk("all_clk_off", 16'(clk_gated_o), 16'h0);
    chk("cnt_1", sleep_cnt_o, STATS ? 16'd1 : 16'd0);
    tick();
    chk("hold_sleep", 16'(dom_sleep_o), 16'hF);
    chk("cnt_2", sleep_cnt_o, STATS ? 16'd2 : 16'd0);

    // wake pulse on domain 2: clock in the wake cycle, 2 WAKE cycles, RUN
    dom_wake_i = 4'h4;
    tick();                                                  // d2 WAKE2
    chk("wake_clk",   16'(clk_gated_o), 16'h4);
    chk("wake_core",  16'(core_sleep_o), 16'h0);
    chk("wake_sleep", 16'(dom_sleep_o), 16'hB);
    dom_wake_i = 4'h8;                                       // busy+wake on d3 = one wake
    dom_busy_i = 4'h8;
    tick();                                                  // d2 WAKE1, d3 WAKE2
    dom_wake_i = 4'h0;
    chk("bw_clk",   16'(clk_gated_o), 16'hC);
    chk("bw_sleep", 16'(dom_sleep_o), 16'h3);
    tick();                                                  // d2 RUN, d3 WAKE1
    chk("w1_sleep", 16'(dom_sleep_o), 16'h3);
    tick();                                                  // d2 SLEEP, d3 RUN
    chk("d2_resleep", 16'(dom_sleep_o), 16'h7);
    chk("d2_run_clk", 16'(clk_gated_o), 16'hC);
    tick();
    chk("d3_run_clk", 16'(clk_gated_o), 16'h8);

    // external permit low gates clocks but states still advance
    clk_en_ext_i = 1'b0;
    dom_busy_i = 4'h0;
    tick();
    chk("ext_clk",   16'(clk_gated_o), 16'h0);
    chk("ext_sleep", 16'(dom_sleep_o), 16'hF);
    clk_en_ext_i = 1'b1;
    scan_cg_en_i = 1'b1;
    tick();
    chk("scan_clk", 16'(clk_gated_o), 16'hF);
    scan_cg_en_i = 1'b0;
    tick();
    chk("noscan_clk", 16'(clk_gated_o), 16'h0);
    chk("cnt_5", sleep_cnt_o, STATS ? 16'd5 : 16'd0);

    // long core sleep: counter saturates (or stays 0)
    for (int n = 0; n < (STATS ? 70000 : 20); n++) tick();
    chk("cnt_sat", sleep_cnt_o, STATS ? 16'hFFFF : 16'h0);
    chk("long_sleep", 16'(dom_sleep_o), 16'hF);

    // reset asserted mid-WAKE aborts immediately
    dom_wake_i = 4'h1;
    tick();
    dom_wake_i = 4'h0;
    chk("pre_rst_sleep", 16'(dom_sleep_o), 16'hE);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sleep", 16'(dom_sleep_o), 16'h0);
    chk("arst_fe",    16'(fetch_enable_o), 16'h0);
    chk("arst_cnt",   sleep_cnt_o, 16'h0);
    tick(); tick();
    chk("arst_clk", 16'(clk_gated_o), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
